lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the LFSR word width (N >= 2).
REQ-002 The block SHALL have parameter POLY, N bits wide, default 8'h3C, giving the Galois feedback taps.
REQ-003 The block SHALL have parameter LOCK_CNT, default 4, giving the consecutive matches needed to lock (1..255).
REQ-004 The block SHALL have parameter ERR_THRESH, default 3, giving the consecutive mismatches that drop lock (1..255).
REQ-005 The block SHALL have parameter CNT_W, default 16, giving the error counter width.
REQ-006 The block SHALL have port i_clk, input, 1 bit: clock, all logic on the rising edge.
REQ-007 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port i_valid, input, 1 bit: i_data carries a received LFSR word this cycle.
REQ-009 The block SHALL have port i_data, input, N bits: received LFSR state word.
REQ-010 The block SHALL have port i_clear, input, 1 bit: synchronous clear of o_err_cnt.
REQ-011 The block SHALL have port o_locked, output, 1 bit: checker is in LOCK state.
REQ-012 The block SHALL have port o_err, output, 1 bit: one-cycle pulse per mismatching beat while locked.
REQ-013 The block SHALL have port o_err_cnt, output, CNT_W bits: saturating count of locked-state mismatches.

Function
REQ-014 The block SHALL use next(x) = {x[N-2:0],1'b0} XOR (POLY AND {N{x[N-1]}}), the same step as the team's LFSR generator.
REQ-015 The block SHALL implement two states, HUNT and LOCK, with o_locked = (state == LOCK), registered.
REQ-016 The block SHALL hold internal reference register ref, a ref_valid flag, match counter mcnt and miss counter xcnt.
REQ-017 The block SHALL ignore all cycles with i_valid low: no state, counter or ref change, and o_err low.
REQ-018 In HUNT, on a valid beat with i_data != 0, ref_valid = 1 and i_data == next(ref), the block SHALL increment mcnt; otherwise it SHALL clear mcnt.
REQ-019 In HUNT, every valid beat SHALL load ref <= i_data, with ref_valid <= (i_data != 0); the all-zero lock-up word never counts as a match.
REQ-020 In HUNT, the block SHALL enter LOCK on the beat where mcnt reaches LOCK_CNT, with o_locked high on the following cycle.
REQ-021 In LOCK, each valid beat SHALL advance ref <= next(ref) regardless of i_data (flywheel); received data never reloads ref.
REQ-022 In LOCK, if i_data == next(ref), the block SHALL clear xcnt; otherwise it SHALL pulse o_err the next cycle, increment o_err_cnt saturating at all-ones, and increment xcnt.
REQ-023 In LOCK, when xcnt reaches ERR_THRESH, the block SHALL return to HUNT next cycle and clear mcnt, xcnt and ref_valid; the ERR_THRESH-th mismatch still pulses o_err and counts.
REQ-024 The block SHALL clear o_err_cnt to 0 when i_clear is high; i_clear SHALL win over a simultaneous increment. State, lock and o_err SHALL be unaffected.
REQ-025 All outputs SHALL be registered, with one-cycle latency from the causing valid beat.

Reset
REQ-026 Asserting i_rst_n low SHALL, asynchronously and at any time including mid-lock: set state HUNT, o_locked 0, o_err 0, o_err_cnt 0, ref 0, ref_valid 0, mcnt 0, xcnt 0.
REQ-027 After reset release, the block SHALL require a full LOCK_CNT+1-beat acquisition before o_locked rises.

Configuration
REQ-028 With macro LFSR_CHECKER_ERR_CNT_EN defined, the block SHALL implement the o_err_cnt counter and i_clear per REQ-022/REQ-024.
REQ-029 Without LFSR_CHECKER_ERR_CNT_EN, the block SHALL tie o_err_cnt to 0, ignore i_clear, and leave o_err and lock behaviour unchanged.

Verification (N=8, POLY=8'h3C, LOCK_CNT=4, ERR_THRESH=3, macro defined)
REQ-030 Acquire: valid beats 01,02,04,08,10 -> o_locked 0 until the cycle after the 10 beat, then 1; o_err never pulses.
REQ-031 Single error: after lock, beats 20,40,FF,3C,78 -> one o_err pulse, in the cycle after FF; o_err_cnt = 1; o_locked stays 1 because the flywheel predicts 80 then 3C.
REQ-032 Loss of lock: after lock, beats 55,55,55 -> three o_err pulses, o_err_cnt = 3, and o_locked falls the cycle after the third beat; re-feeding a valid run relocks.
REQ-033 Zero stuck: beats 00 x10 from reset -> o_locked stays 0 and mcnt stays 0.
REQ-034 Clear/reset: i_clear coincident with a mismatch beat -> o_err_cnt = 0 and o_err still pulses; asserting i_rst_n low mid-lock -> all outputs 0 immediately.
REQ-035 Gaps and saturation: i_valid low between valid beats -> behaviour identical to a gapless stream; with CNT_W=2, five locked mismatches -> o_err_cnt holds 3.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: locks onto a received Galois LFSR word stream, then flywheels
// its own reference. It flags mismatching beats and drops lock after
// ERR_THRESH consecutive mismatches.
//
// Optional feature: define LFSR_CHECKER_ERR_CNT_EN to build the saturating
// o_err_cnt counter and its i_clear. Without the macro, o_err_cnt is tied to 0
// and i_clear is ignored.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_valid    i_data carries a received LFSR word this cycle
//   i_data     received LFSR state word (N bits)
//   i_clear    synchronous clear of o_err_cnt
//   o_locked   registered, high while in LOCK
//   o_err      registered one-cycle pulse per mismatching beat while locked
//   o_err_cnt  registered saturating count of locked-state mismatches (CNT_W bits)
module lfsr_checker #(
  parameter int unsigned     N          = 8,
  parameter logic [N-1:0]    POLY       = 8'h3C,
  parameter int unsigned     LOCK_CNT   = 4,
  parameter int unsigned     ERR_THRESH = 3,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [N-1:0]     i_data,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int unsigned CW = 8;

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  // One Galois LFSR step, identical to the generator's step
  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] x);
    return {x[N-2:0], 1'b0} ^ (POLY & {N{x[N-1]}});
  endfunction

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  ref_q, ref_d;
  logic          ref_valid_q, ref_valid_d;
  logic [CW-1:0] mcnt_q, mcnt_d;
  logic [CW-1:0] xcnt_q, xcnt_d;
  logic          err_d;
  logic [N-1:0]  pred_c;

  assign pred_c = lfsr_next(ref_q);

  // State and tracking registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= HUNT;
      ref_q       <= '0;
      ref_valid_q <= 1'b0;
      mcnt_q      <= '0;
      xcnt_q      <= '0;
      o_locked    <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      ref_valid_q <= ref_valid_d;
      mcnt_q      <= mcnt_d;
      xcnt_q      <= xcnt_d;
      o_locked    <= (state_d == LOCK);
      o_err       <= err_d;
    end
  end

  // Next-state logic: hunt reloads ref from the stream, lock flywheels it
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    ref_valid_d = ref_valid_q;
    mcnt_d      = mcnt_q;
    xcnt_d      = xcnt_q;
    err_d       = 1'b0;
    if (i_valid) begin
      case (state_q)
        HUNT: begin
          ref_d       = i_data;
          ref_valid_d = (i_data != '0);
          if ((i_data != '0) && ref_valid_q && (i_data == pred_c)) begin
            if (({1'b0, mcnt_q} + 9'd1) >= 9'(LOCK_CNT)) begin
              state_d = LOCK;
              mcnt_d  = '0;
              xcnt_d  = '0;
            end else begin
              mcnt_d = mcnt_q + CW'(1);
            end
          end else begin
            mcnt_d = '0;
          end
        end
        LOCK: begin
          ref_d = pred_c;
          if (i_data == pred_c) begin
            xcnt_d = '0;
          end else begin
            err_d = 1'b1;
            if (({1'b0, xcnt_q} + 9'd1) >= 9'(ERR_THRESH)) begin
              state_d     = HUNT;
              xcnt_d      = '0;
              mcnt_d      = '0;
              ref_valid_d = 1'b0;
            end else begin
              xcnt_d = xcnt_q + CW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

`ifdef LFSR_CHECKER_ERR_CNT_EN
  // Saturating mismatch counter; clear wins over a simultaneous increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt <= '0;
    end else if (i_clear) begin
      o_err_cnt <= '0;
    end else if (err_d && (o_err_cnt != '1)) begin
      o_err_cnt <= o_err_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_clear;
  assign unused_clear = i_clear;
  assign o_err_cnt    = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: the driver updates a behavioural model per
// cycle and queues the expected outputs; a monitor compares after each edge.
module tb_lfsr_checker;

  localparam int unsigned N          = 8;
  localparam logic [7:0]  POLY       = 8'h3C;
  localparam int unsigned LOCK_CNT   = 4;
  localparam int unsigned ERR_THRESH = 3;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned SAT_W      = 2;
`ifdef LFSR_CHECKER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid = 1'b0;
  logic [N-1:0]     data = '0;
  logic             clear = 1'b0;
  logic             locked, err, locked_s, err_s;
  logic [CNT_W-1:0] err_cnt;
  logic [SAT_W-1:0] err_cnt_s;

  always #5 clk = ~clk;

  lfsr_checker #(.N(N), .POLY(POLY), .LOCK_CNT(LOCK_CNT), .ERR_THRESH(ERR_THRESH),
                 .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .i_clear(clear),
    .o_locked(locked), .o_err(err), .o_err_cnt(err_cnt));

  lfsr_checker #(.N(N), .POLY(POLY), .LOCK_CNT(LOCK_CNT), .ERR_THRESH(ERR_THRESH),
                 .CNT_W(SAT_W)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .i_clear(clear),
    .o_locked(locked_s), .o_err(err_s), .o_err_cnt(err_cnt_s));

  typedef struct packed {
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] cnt;
    logic [SAT_W-1:0] scnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Behavioural model state
  bit m_locked, m_have_prev, m_err;
  int m_prev, m_run, m_miss, m_cnt;

  // Multiply by x modulo the feedback polynomial, on plain integers
  function automatic int step(input int x);
    int y;
    y = (x * 2) % 256;
    if (x >= 128) y = y ^ int'(POLY);
    return y;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_have_prev = 0; m_err = 0;
    m_prev = 0; m_run = 0; m_miss = 0; m_cnt = 0;
  endtask

  task automatic model_beat(input bit v, input int d, input bit c);
    int p;
    m_err = 0;
    if (v) begin
      if (!m_locked) begin
        if (d != 0 && m_have_prev && d == step(m_prev)) m_run++;
        else m_run = 0;
        m_prev = d;
        m_have_prev = (d != 0);
        if (m_run == int'(LOCK_CNT)) begin
          m_locked = 1; m_run = 0; m_miss = 0;
        end
      end else begin
        p = step(m_prev);
        m_prev = p;
        if (d == p) m_miss = 0;
        else begin
          m_err = 1; m_cnt++; m_miss++;
          if (m_miss == int'(ERR_THRESH)) begin
            m_locked = 0; m_run = 0; m_miss = 0; m_have_prev = 0;
          end
        end
      end
    end
    if (c) m_cnt = 0;
    if (m_cnt > 100000) m_cnt = 100000;
  endtask

  // Drive one cycle and queue the outputs expected after its edge
  task automatic beat(input bit v, input logic [7:0] d, input bit c);
    exp_t e;
    @(negedge clk);
    valid = v; data = d; clear = c;
    model_beat(v, int'(d), c);
    e.locked = m_locked;
    e.err    = m_err;
    e.cnt    = CNT_EN ? CNT_W'(sat(m_cnt, CNT_W)) : '0;
    e.scnt   = CNT_EN ? SAT_W'(sat(m_cnt, SAT_W)) : '0;
    q.push_back(e);
  endtask

  task automatic seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                     input logic [7:0] d, input logic [7:0] e);
    beat(1, a, 0); beat(1, b, 0); beat(1, c, 0); beat(1, d, 0); beat(1, e, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid = 0; clear = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== '0 ||
        locked_s !== 1'b0 || err_s !== 1'b0 || err_cnt_s !== '0) begin
      failures++;
      $display("FAIL async_reset: got locked=%b err=%b cnt=%0d sat_locked=%b sat_err=%b sat_cnt=%0d, want all 0",
               locked, err, err_cnt, locked_s, err_s, err_cnt_s);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs against queued expectations after each edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (locked !== e.locked || err !== e.err || err_cnt !== e.cnt ||
          locked_s !== e.locked || err_s !== e.err || err_cnt_s !== e.scnt) begin
        failures++;
        $display("FAIL outputs @%0t: got locked=%b err=%b cnt=%0d sat(locked=%b err=%b cnt=%0d) want locked=%b err=%b cnt=%0d sat_cnt=%0d",
                 $time, locked, err, err_cnt, locked_s, err_s, err_cnt_s,
                 e.locked, e.err, e.cnt, e.scnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g, d;
    int r;
    model_reset();
    #1;
    checks++;
    if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== '0) begin
      failures++;
      $display("FAIL reset_state: got locked=%b err=%b cnt=%0d want 0 0 0", locked, err, err_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Zero stuck: all-zero words never acquire
    repeat (10) beat(1, 8'h00, 0);
    // Acquire, then a single error absorbed by the flywheel
    seq(8'h01, 8'h02, 8'h04, 8'h08, 8'h10);
    seq(8'h20, 8'h40, 8'hFF, 8'h3C, 8'h78);
    // Loss of lock, then relock
    beat(1, 8'h55, 0); beat(1, 8'h55, 0); beat(1, 8'h55, 0);
    seq(8'h01, 8'h02, 8'h04, 8'h08, 8'h10);
    // Clear coincident with a mismatch
    beat(1, 8'h20, 0); beat(1, 8'h11, 1); beat(1, 8'h80, 0);
    // Five locked mismatches separated by good beats saturate the 2-bit counter
    g = 8'h80;
    for (int i = 0; i < 5; i++) begin
      g = 8'(step(int'(g))); beat(1, ~g, 0);
      g = 8'(step(int'(g))); beat(1, g, 0);
    end
    // Gapped acquisition
    do_reset();
    g = 8'h01;
    beat(1, g, 0);
    for (int i = 0; i < 6; i++) begin
      beat(0, 8'hA5, 0); beat(0, 8'h00, 0);
      g = 8'(step(int'(g))); beat(1, g, 0);
    end
    // Reset mid-lock, then full reacquisition required
    do_reset();
    seq(8'h02, 8'h04, 8'h08, 8'h10, 8'h20);

    // Randomized stream with errors, gaps, zeros, clears and reseeds
    g = 8'h5A;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15) begin
        beat(0, 8'($urandom), ($urandom_range(0, 49) == 0));
      end else begin
        if (r == 99) g = 8'($urandom_range(1, 255));
        g = 8'(step(int'(g)));
        d = g;
        if (r < 25) d = 8'($urandom);
        else if (r < 27) d = 8'h00;
        beat(1, d, ($urandom_range(0, 49) == 0));
      end
    end

    beat(0, 8'h00, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
